// File: rtl/exgcd_pkg.sv
// exgcd_pkg: shared width default and FSM state encoding for the modular-inverse checker.
package exgcd_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, NORM, MUL, DONE} state_t;
endpackage

// File: rtl/modmul_shift_add.sv
// modmul_shift_add: serial MSB-first shift-add modular multiply, acc = a_r*x mod b in WIDTH cycles.
module modmul_shift_add
  import exgcd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_r,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH+1:0] b_w, t1, t, u1, u;
  logic [WIDTH-1:0] acc_q, sh_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  // operands stay below b, so each mod needs only one conditional subtract
  assign b_w  = {2'b00, b};
  assign t1   = {1'b0, acc_q, 1'b0};
  assign t    = t1 >= b_w ? t1 - b_w : t1;
  assign u1   = t + (sh_q[WIDTH-1] ? {2'b00, a_r} : '0);
  assign u    = u1 >= b_w ? u1 - b_w : u1;
  assign done = busy_q && cnt_q == CW'(WIDTH - 1);
  assign acc  = acc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      acc_q  <= '0;
      sh_q   <= x;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q  <= u[WIDTH-1:0];
      sh_q   <= sh_q << 1;
      cnt_q  <= cnt_q + CW'(1);
      busy_q <= !done;
    end
  end
endmodule

// File: rtl/modinv_check.sv
// modinv_check: normalises a Bezout coefficient into [0,b) and verifies a*x mod b == 1.
module modinv_check
  import exgcd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] gcd,
  input  logic [WIDTH-1:0] inv,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             valid_out,
  output logic [WIDTH-1:0] inv_mod,
  output logic             has_inv,
  output logic             check_ok,
  output logic [7:0]       drop_cnt
);
  state_t                state_q, state_d;
  logic [WIDTH-1:0]      a_q, b_q, g_q, inv_mod_q, acc, a_n;
  logic signed [WIDTH:0] x_q, x_n, b_s;
  logic [7:0]            drop_q;
  logic                  valid_out_q, has_inv_q, check_ok_q, good, norm_exit, start, mul_done;
  assign b_s       = $signed({1'b0, b_q});
  assign x_n       = x_q[WIDTH] ? x_q + b_s : (x_q >= b_s ? x_q - b_s : x_q);
  assign a_n       = a_q >= b_q ? a_q - b_q : a_q;
  assign good      = g_q == WIDTH'(1) && b_q >= WIDTH'(2);
  // exit is judged on the values this cycle produces, so an in-range pair leaves after one step
  assign norm_exit = !x_n[WIDTH] && x_n < b_s && a_n < b_q;
  assign start     = state_q == NORM && good && norm_exit;
  assign in_ready  = state_q == IDLE;
  assign valid_out = valid_out_q;
  assign inv_mod   = inv_mod_q;
  assign has_inv   = has_inv_q;
  assign check_ok  = check_ok_q;
  assign drop_cnt  = drop_q;
  modmul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst_n(rst_n), .start(start), .a_r(a_q), .x(x_n[WIDTH-1:0]), .b(b_q),
    .acc(acc), .done(mul_done)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_in) state_d = NORM;
      NORM:    if (!good) state_d = DONE; else if (norm_exit) state_d = MUL;
      MUL:     if (mul_done) state_d = DONE;
      default: if (valid_out_q && out_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      g_q         <= '0;
      x_q         <= '0;
      drop_q      <= '0;
      valid_out_q <= 1'b0;
      inv_mod_q   <= '0;
      has_inv_q   <= 1'b0;
      check_ok_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (valid_in && state_q != IDLE && drop_q != 8'hff) drop_q <= drop_q + 8'd1;
      if (state_q == IDLE && valid_in) begin
        a_q <= data_a;
        b_q <= data_b;
        g_q <= gcd;
        x_q <= {inv[WIDTH-1], inv};
      end
      if (state_q == NORM && good) begin
        x_q <= x_n;
        a_q <= a_n;
      end
      // first DONE cycle loads the results; the following cycles hold them for the handshake
      if (state_q == DONE && !valid_out_q) begin
        valid_out_q <= 1'b1;
        inv_mod_q   <= good ? x_q[WIDTH-1:0] : '0;
        has_inv_q   <= good;
        check_ok_q  <= good && acc == WIDTH'(1);
      end
      if (valid_out_q && out_ready) valid_out_q <= 1'b0;
    end
  end
endmodule

// File: doc/modinv_check.md
MODINV_CHECK -- requirements
Module: modinv_check

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand, gcd and coefficient width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port valid_in, input, 1, one-cycle strobe qualifying data_a/data_b/gcd/inv.
REQ-005 The block SHALL have port data_a, input, WIDTH, unsigned operand a.
REQ-006 The block SHALL have port data_b, input, WIDTH, unsigned modulus b.
REQ-007 The block SHALL have port gcd, input, WIDTH, unsigned gcd(a,b) from the upstream exgcd stage.
REQ-008 The block SHALL have port inv, input, WIDTH, two's-complement Bezout coefficient x with a*x ≡ gcd (mod b).
REQ-009 The block SHALL have port in_ready, output, 1, high only in IDLE.
REQ-010 The block SHALL have port out_ready, input, 1, downstream acceptance.
REQ-011 The block SHALL have port valid_out, output, 1, result valid; held until accepted.
REQ-012 The block SHALL have port inv_mod, output, WIDTH, normalised inverse in [0,b), else 0.
REQ-013 The block SHALL have port has_inv, output, 1, set when gcd==1 and b>=2.
REQ-014 The block SHALL have port check_ok, output, 1, set when (a*inv_mod) mod b == 1.
REQ-015 The block SHALL have port drop_cnt, output, 8, saturating count of valid_in pulses dropped.

Function
REQ-016 The FSM SHALL have states IDLE, NORM, MUL, DONE.
REQ-017 IDLE + valid_in: capture a, b, gcd and sign-extended inv (WIDTH+1 bits) -> NORM; valid_in while not IDLE is ignored and drop_cnt increments (saturating at 255).
REQ-018 Captured b<2 or gcd!=1: next state DONE with inv_mod=0, has_inv=0, check_ok=0 (latency 2 cycles from capture edge to valid_out).
REQ-019 In NORM, each cycle x += b if x<0 or x -= b if x>=b, and a_r -= b if a_r>=b, concurrently; exit to MUL when 0<=x<b and a_r<b.
REQ-020 MUL SHALL run exactly WIDTH cycles, MSB-first over x: acc = (2*acc mod b + (bit ? a_r : 0)) mod b, with each mod being at most one conditional subtraction in a WIDTH+2-bit datapath; acc starts at 0.
REQ-021 After the last MUL cycle -> DONE: inv_mod=x[WIDTH-1:0], has_inv=1, check_ok=(acc==1).
REQ-022 In DONE, valid_out=1 with stable outputs; on out_ready=1 -> IDLE next cycle; valid_out and out_ready both high in the same cycle is a transfer.
REQ-023 After a transfer, inv_mod/has_inv/check_ok SHALL hold their values until the next DONE, with valid_out=0.
REQ-024 Every output SHALL be registered; no combinational path from input to output except in_ready, which decodes state only.

Reset
REQ-025 With rst_n low, at any time including mid-NORM/MUL, the block SHALL go to IDLE immediately; valid_out, inv_mod, has_inv, check_ok and drop_cnt SHALL be 0, in_ready=1, and all internal registers cleared.
REQ-026 An in-flight computation interrupted by reset SHALL be discarded with no output.

Structure
REQ-027 Package exgcd_pkg SHALL hold WIDTH default and the state enum (IDLE, NORM, MUL, DONE).
REQ-028 The serial modular multiply SHALL be sub-module modmul_shift_add (start, a_r, x, b -> acc, done), which the FSM instantiates once.

Verification
REQ-029 a=9, b=7, gcd=1, inv=-3 -> NORM 1 cycle, then 8 MUL cycles; inv_mod=4, has_inv=1, check_ok=1, valid_out 10 cycles after capture.
REQ-030 a=15, b=24, gcd=3, inv=-3 -> inv_mod=0, has_inv=0, check_ok=0, valid_out 2 cycles after capture.
REQ-031 a=200, b=3, gcd=1, inv=-1 -> 66 NORM cycles, then inv_mod=2, has_inv=1, check_ok=1.
REQ-032 a=9, b=7, gcd=1, inv=3 (wrong coefficient) -> inv_mod=3, has_inv=1, check_ok=0.
REQ-033 Hold out_ready=0 for 5 cycles in DONE and pulse valid_in twice -> outputs stable, drop_cnt=2; then out_ready=1 -> IDLE.
REQ-034 Assert rst_n=0 during MUL of the REQ-029 case -> all outputs 0 asynchronously, no valid_out after release; a re-issued request completes normally.
